setup_capture: RTL and testbench
================================

# setup_capture

Front-end writer for the game's setup register: samples the eight level switches when the player presses the confirm button, debounces the press, and checks the word. A valid word is offered to the control FSM through a valid/ready handshake; a bad word raises a one-cycle error. Sits between the board I/O (switches, confirm key) and the control FSM / setup register load path.

## Interface
- P_SW, 8: switch word width
- DEB_CYCLES, 50000: consecutive stable samples required to accept a press or a release (≥1)
- clk  in  1  system clock, all logic on rising edge
- R  in  1  synchronous, active-low reset
- sw  in  P_SW  raw switch inputs
- enter  in  1  raw confirm button, active-high
- setup_ready  in  1  consumer (control FSM) accepts the offered word
- setup_data  out  P_SW  frozen setup word, valid while setup_valid=1
- setup_valid  out  1  word offered; held until accepted
- level  out  2  setup_data[1:0], the decoded game level
- setup_err  out  1  one-cycle pulse: rejected word

## Operation
- Validity rule: sw[P_SW-1:2] must be all zero; level = sw[1:0], all four values legal.
- FSM states: IDLE, DEB_PRESS, CHECK, OFFER, DEB_REL.
- IDLE: counter cleared; enter=1 → DEB_PRESS.
- DEB_PRESS: counter increments each cycle enter=1; enter=0 at any point → IDLE (counter cleared); counter reaches DEB_CYCLES → CHECK.
- CHECK (1 cycle): snapshot sw into setup_data. Valid → OFFER. Invalid → pulse setup_err, setup_data unchanged, → DEB_REL.
- OFFER: setup_valid=1, setup_data frozen regardless of sw/enter; transfer occurs on a cycle with setup_valid=1 and setup_ready=1; next state DEB_REL.
- DEB_REL: counter counts consecutive enter=0 cycles; enter=1 restarts count; reaching DEB_CYCLES → IDLE. Prevents a held key from producing a second capture.
- setup_ready while setup_valid=0: ignored.
- Counter width: clog2(DEB_CYCLES+1); saturates, never wraps.

## Timing
- Reset (R=0 at a rising edge): state IDLE, counter 0, setup_data 0, level 0, setup_valid 0, setup_err 0, all on the next edge. Reset mid-OFFER drops setup_valid without a transfer.
- Without synchronizer: enter rising at edge n with stable press → CHECK at edge n+DEB_CYCLES, setup_valid (or setup_err) high from edge n+DEB_CYCLES+1.
- With synchronizer: add 2 cycles to all input-to-output latencies.
- setup_ready already high when setup_valid rises: transfer in that same cycle; setup_valid high exactly one cycle.
- setup_err: exactly one cycle high per rejected press.
- level is combinational from setup_data (no extra latency).

## Configuration
- SETUP_CAPTURE_SYNC_EN defined: sw and enter pass through two-flop synchronizers (reset to 0) before any use; latency +2 cycles.
- Not defined: raw inputs used directly (for simulation / pre-synchronized sources); latency as stated above.

## Structure
- Shared package: FSM state encoding constants (IDLE..DEB_REL), level encoding constants (LVL_0..LVL_3), P_SW default.
- One sub-module: sync2 (parameterized-width two-flop synchronizer), instantiated only under SETUP_CAPTURE_SYNC_EN.

## Test plan
(DEB_CYCLES=4, macro undefined unless noted.)
- Reset: drive R=0 one edge with sw=8'hFF, enter=1 → all outputs 0, no valid/err for 1 cycle after R rises while enter stays 0.
- Clean press: sw=8'h02, enter=1 for 10 cycles, setup_ready=0 → setup_valid high from cycle 5, setup_data=8'h02, level=2; hold 3 cycles then ready=1 → valid drops next edge; no second offer until enter low 4 cycles and pressed again.
- Bounce: enter pattern 1,1,0,1,1,1,1 with sw=8'h01 → exactly one offer, starting 5 cycles after last rising of enter.
- Invalid word: sw=8'h81, press 6 cycles → setup_err one cycle, setup_valid never set, setup_data keeps previous value.
- Data freeze and reset mid-offer: offer sw=8'h03, change sw to 8'h00 during OFFER → setup_data stays 8'h03; assert R=0 → setup_valid 0 next edge, no transfer counted.
- SYNC_EN build: repeat clean-press case → setup_valid rises 2 cycles later (cycle 7).

Source files
------------

// File: rtl/setup_capture_pkg.sv
// -----------------------------------------------------------------------------
// setup_capture_pkg
// Shared definitions for the setup-word capture front end.
//   - P_SW_DEF : default switch word width
//   - state_t  : capture FSM state encoding (IDLE .. DEB_REL)
//   - level_t  : decoded game level encoding (LVL_0 .. LVL_3)
// -----------------------------------------------------------------------------
package setup_capture_pkg;

   localparam int P_SW_DEF = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      DEB_PRESS = 3'd1,
      CHECK     = 3'd2,
      OFFER     = 3'd3,
      DEB_REL   = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      LVL_0 = 2'd0,
      LVL_1 = 2'd1,
      LVL_2 = 2'd2,
      LVL_3 = 2'd3
   } level_t;

endpackage

// File: rtl/setup_capture_sync2.sv
// -----------------------------------------------------------------------------
// setup_capture_sync2
// Parameterized-width two-flop synchronizer for asynchronous board inputs.
// Both stages clear to 0 on reset.
// Ports:
//   clk  in   system clock
//   R    in   synchronous active-low reset
//   d    in   [W-1:0] asynchronous input
//   q    out  [W-1:0] synchronized output (2 cycles of latency)
// -----------------------------------------------------------------------------
module setup_capture_sync2 #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         R,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta;

   always_ff @(posedge clk) begin
      if (!R) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/setup_capture.sv
// -----------------------------------------------------------------------------
// setup_capture
// Samples the level switches when the confirm key is pressed, debounces the
// press and the release, checks the word and offers a valid word to the
// control FSM over a valid/ready handshake. A bad word gives a one-cycle
// setup_err pulse instead.
//
// Handshake: setup_valid rises with setup_data already stable; setup_data is
// frozen while setup_valid=1; a transfer happens on any rising edge where
// setup_valid=1 and setup_ready=1, and setup_valid drops on that same edge.
// setup_ready is ignored while setup_valid=0.
//
// Configuration macro: SETUP_CAPTURE_SYNC_EN
//   defined   : sw and enter go through two-flop synchronizers (+2 cycles)
//   undefined : raw sw and enter are used directly
//
// Ports:
//   clk          in   system clock, rising edge
//   R            in   synchronous active-low reset
//   sw           in   [P_SW-1:0] raw switch word
//   enter        in   raw confirm key, active-high
//   setup_ready  in   consumer accepts the offered word
//   setup_data   out  [P_SW-1:0] frozen setup word
//   setup_valid  out  word offered, held until accepted
//   level        out  [1:0] setup_data[1:0]
//   setup_err    out  one-cycle pulse for a rejected word
// -----------------------------------------------------------------------------
module setup_capture
   import setup_capture_pkg::*;
#(
   parameter int P_SW       = P_SW_DEF,
   parameter int DEB_CYCLES = 50000
) (
   input  logic            clk,
   input  logic            R,
   input  logic [P_SW-1:0] sw,
   input  logic            enter,
   input  logic            setup_ready,
   output logic [P_SW-1:0] setup_data,
   output logic            setup_valid,
   output logic [1:0]      level,
   output logic            setup_err
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEB_CYCLES);

   logic [P_SW-1:0] sw_s;
   logic            enter_s;

`ifdef SETUP_CAPTURE_SYNC_EN
   logic [P_SW:0] sync_q;

   setup_capture_sync2 #(
      .W (P_SW + 1)
   ) u_sync (
      .clk (clk),
      .R   (R),
      .d   ({sw, enter}),
      .q   (sync_q)
   );

   assign sw_s    = sync_q[P_SW:1];
   assign enter_s = sync_q[0];
`else
   assign sw_s    = sw;
   assign enter_s = enter;
`endif

   // state is the FSM debug point that checkers bind to
   state_t        state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_inc;
   logic          word_ok;

   // Saturating increment: the counter never wraps.
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
   assign word_ok = (sw_s[P_SW-1:2] == '0);
   assign level   = setup_data[1:0];

   always_ff @(posedge clk) begin
      if (!R) begin
         state       <= IDLE;
         cnt         <= '0;
         setup_data  <= '0;
         setup_valid <= 1'b0;
         setup_err   <= 1'b0;
      end else begin
         setup_err <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (enter_s) state <= DEB_PRESS;
            end
            // The cycle that left IDLE saw the key high; DEB_CYCLES further
            // consecutive high samples reach CHECK.
            DEB_PRESS: begin
               if (!enter_s) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= CHECK;
                  cnt   <= cnt_inc;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            CHECK: begin
               cnt <= '0;
               if (word_ok) begin
                  setup_data  <= sw_s;
                  setup_valid <= 1'b1;
                  state       <= OFFER;
               end else begin
                  setup_err <= 1'b1;
                  state     <= DEB_REL;
               end
            end
            OFFER: begin
               if (setup_ready) begin
                  setup_valid <= 1'b0;
                  cnt         <= '0;
                  state       <= DEB_REL;
               end
            end
            // Wait for a clean release so a held key cannot capture twice.
            DEB_REL: begin
               if (enter_s) begin
                  cnt <= '0;
               end else if (cnt == CNT_LAST) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else begin
                  cnt <= cnt_inc;
               end
            end
            default: begin
               state       <= IDLE;
               cnt         <= '0;
               setup_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_setup_capture.sv
module tb_setup_capture;
   import setup_capture_pkg::*;

   localparam int DEB = 4;
`ifdef SETUP_CAPTURE_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif
   // edge index (0 = first edge with enter high) of the first output edge
   localparam int FIRST_OUT = DEB + 1 + LAT;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       R;
   logic [7:0] sw;
   logic       enter;
   logic       setup_ready;
   logic [7:0] setup_data;
   logic       setup_valid;
   logic [1:0] level;
   logic       setup_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   setup_capture #(
      .P_SW       (8),
      .DEB_CYCLES (DEB)
   ) dut (
      .clk         (clk),
      .R           (R),
      .sw          (sw),
      .enter       (enter),
      .setup_ready (setup_ready),
      .setup_data  (setup_data),
      .setup_valid (setup_valid),
      .level       (level),
      .setup_err   (setup_err)
   );

   // ---------------- reference model ----------------
   // Rule-based view: after a quiet period the key must be seen high for
   // DEB+1 consecutive samples; the word present one sample later is judged.
   // A judged press needs DEB consecutive low samples before the next press.
   int         m_hi, m_lo;
   bit         m_check, m_offer, m_rel, m_err;
   logic [7:0] m_data;
   logic       m_e1, m_e2;
   logic [7:0] m_sw1, m_sw2;

   always @(posedge clk) begin : ref_model
      logic       e;
      logic [7:0] s;
`ifdef SETUP_CAPTURE_SYNC_EN
      e = m_e2;
      s = m_sw2;
`else
      e = enter;
      s = sw;
`endif
      if (!R) begin
         m_hi = 0; m_lo = 0;
         m_check = 0; m_offer = 0; m_rel = 0; m_err = 0;
         m_data = 8'h00;
         m_e1 = 0; m_e2 = 0; m_sw1 = 8'h00; m_sw2 = 8'h00;
      end else begin
         m_err = 0;
         if (m_check) begin
            m_check = 0;
            if (s[7:2] == 6'd0) begin
               m_data  = s;
               m_offer = 1;
            end else begin
               m_err = 1;
               m_rel = 1;
               m_lo  = 0;
            end
         end else if (m_offer) begin
            if (setup_ready) begin
               m_offer = 0;
               m_rel   = 1;
               m_lo    = 0;
            end
         end else if (m_rel) begin
            if (e) m_lo = 0;
            else   m_lo = m_lo + 1;
            if (m_lo == DEB) begin
               m_rel = 0;
               m_hi  = 0;
            end
         end else begin
            if (e) m_hi = m_hi + 1;
            else   m_hi = 0;
            if (m_hi == DEB + 1) begin
               m_check = 1;
               m_hi    = 0;
            end
         end
         m_e2 = m_e1; m_e1 = enter;
         m_sw2 = m_sw1; m_sw1 = sw;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic e, input logic [7:0] s, input logic rdy);
      enter       = e;
      sw          = s;
      setup_ready = rdy;
      @(negedge clk);
   endtask

   task automatic release_idle();
      for (int i = 0; i < DEB + LAT + 4; i++) drive(1'b0, 8'h00, 1'b1);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      R = 1'b0;
      drive(1'b1, 8'hFF, 1'b1);
      n_checks++; if (setup_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", setup_valid); end
      n_checks++; if (setup_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", setup_err); end
      n_checks++; if (setup_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", setup_data); end
      n_checks++; if (level !== 2'd0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
      R = 1'b1;
      drive(1'b0, 8'hFF, 1'b0);
      n_checks++; if (setup_valid !== 1'b0 || setup_err !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_quiet: got valid=%b err=%b expected 0/0", setup_valid, setup_err);
      end
      drive(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_clean_press();
      int first = -1;
      int nv = 0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 8'h02, 1'b0);
         if (setup_valid === 1'b1 && first < 0) first = i;
      end
      n_checks++; if (first !== FIRST_OUT) begin n_fail++; $display("FAIL press_latency: got %0d expected %0d", first, FIRST_OUT); end
      n_checks++; if (setup_data !== 8'h02) begin n_fail++; $display("FAIL press_data: got %h expected 02", setup_data); end
      n_checks++; if (level !== LVL_2) begin n_fail++; $display("FAIL press_level: got %0d expected 2", level); end
      for (int i = 0; i < 3; i++) drive(1'b1, 8'h02, 1'b0);
      n_checks++; if (setup_valid !== 1'b1) begin n_fail++; $display("FAIL press_hold: got %b expected 1", setup_valid); end
      drive(1'b1, 8'h02, 1'b1);
      n_checks++; if (setup_valid !== 1'b0) begin n_fail++; $display("FAIL press_accept: got %b expected 0", setup_valid); end
      // held key, short release, then held again: no second capture
      for (int i = 0; i < 6; i++) begin drive(1'b1, 8'h02, 1'b1); nv += int'(setup_valid); end
      for (int i = 0; i < 3; i++) begin drive(1'b0, 8'h02, 1'b1); nv += int'(setup_valid); end
      for (int i = 0; i < 8; i++) begin drive(1'b1, 8'h02, 1'b1); nv += int'(setup_valid); end
      n_checks++; if (nv !== 0) begin n_fail++; $display("FAIL press_no_repeat: got %0d offers expected 0", nv); end
      for (int i = 0; i < DEB + LAT + 1; i++) drive(1'b0, 8'h02, 1'b1);
      nv = 0;
      for (int i = 0; i < 10; i++) begin drive(1'b1, 8'h02, 1'b1); nv += int'(setup_valid); end
      n_checks++; if (nv !== 1) begin n_fail++; $display("FAIL press_second: got %0d valid cycles expected 1", nv); end
      release_idle();
   endtask

   task automatic test_bounce();
      logic [13:0] pat = 14'b11111111111011; // bit i drives cycle i
      int first = -1;
      int nv = 0;
      for (int i = 0; i < 14; i++) begin
         drive(pat[i], 8'h01, 1'b1);
         if (setup_valid === 1'b1) begin
            nv++;
            if (first < 0) first = i;
         end
      end
      n_checks++; if (nv !== 1) begin n_fail++; $display("FAIL bounce_count: got %0d expected 1", nv); end
      n_checks++; if (first !== 3 + FIRST_OUT) begin n_fail++; $display("FAIL bounce_latency: got %0d expected %0d", first, 3 + FIRST_OUT); end
      n_checks++; if (setup_data !== 8'h01 || level !== LVL_1) begin
         n_fail++; $display("FAIL bounce_data: got %h/%0d expected 01/1", setup_data, level);
      end
      release_idle();
   endtask

   task automatic test_invalid();
      int first = -1;
      int ne = 0;
      int nv = 0;
      for (int i = 0; i < 12; i++) begin
         drive(i < 6, 8'h81, 1'b0);
         nv += int'(setup_valid);
         if (setup_err === 1'b1) begin
            ne++;
            if (first < 0) first = i;
         end
      end
      n_checks++; if (ne !== 1) begin n_fail++; $display("FAIL invalid_err_count: got %0d expected 1", ne); end
      n_checks++; if (first !== FIRST_OUT) begin n_fail++; $display("FAIL invalid_err_time: got %0d expected %0d", first, FIRST_OUT); end
      n_checks++; if (nv !== 0) begin n_fail++; $display("FAIL invalid_valid: got %0d expected 0", nv); end
      n_checks++; if (setup_data !== 8'h01) begin n_fail++; $display("FAIL invalid_keep: got %h expected 01", setup_data); end
      release_idle();
   endtask

   task automatic test_freeze_reset();
      for (int i = 0; i < 12; i++) drive(1'b1, 8'h03, 1'b0);
      n_checks++; if (setup_valid !== 1'b1) begin n_fail++; $display("FAIL freeze_offer: got %b expected 1", setup_valid); end
      for (int i = 0; i < 4; i++) drive(1'b0, 8'h00, 1'b0);
      n_checks++; if (setup_data !== 8'h03 || level !== LVL_3) begin
         n_fail++; $display("FAIL freeze_data: got %h/%0d expected 03/3", setup_data, level);
      end
      n_checks++; if (setup_valid !== 1'b1) begin n_fail++; $display("FAIL freeze_hold: got %b expected 1", setup_valid); end
      R = 1'b0;
      drive(1'b0, 8'h00, 1'b0);
      n_checks++; if (setup_valid !== 1'b0 || setup_data !== 8'h00) begin
         n_fail++; $display("FAIL midoffer_reset: got valid=%b data=%h expected 0/00", setup_valid, setup_data);
      end
      R = 1'b1;
      drive(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_random();
      int         run = 0;
      logic       e = 1'b0;
      logic [7:0] s = 8'h00;
      for (int i = 0; i < 800; i++) begin
         if (run == 0) begin
            e   = ~e;
            run = $urandom_range(1, 9);
            if ($urandom_range(0, 3) == 0) s = 8'($urandom);
            else s = {6'd0, 2'($urandom_range(0, 3))};
         end
         run--;
         if ($urandom_range(0, 15) == 0) s = {6'd0, 2'($urandom_range(0, 3))};
         R = ($urandom_range(0, 199) != 0);
         drive(e, s, $urandom_range(0, 2) == 0);
         n_checks++; if (setup_valid !== m_offer) begin n_fail++; $display("FAIL rand_valid @%0d: got %b expected %b", i, setup_valid, m_offer); end
         n_checks++; if (setup_err !== m_err) begin n_fail++; $display("FAIL rand_err @%0d: got %b expected %b", i, setup_err, m_err); end
         n_checks++; if (setup_data !== m_data) begin n_fail++; $display("FAIL rand_data @%0d: got %h expected %h", i, setup_data, m_data); end
         n_checks++; if (level !== m_data[1:0]) begin n_fail++; $display("FAIL rand_level @%0d: got %0d expected %0d", i, level, m_data[1:0]); end
      end
      R = 1'b1;
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      R           = 1'b0;
      enter       = 1'b0;
      sw          = 8'h00;
      setup_ready = 1'b0;
      test_reset();
      test_clean_press();
      test_bounce();
      test_invalid();
      test_freeze_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
